// File: rtl/io_pkg.sv
// ---------------------------------------------------------------------------
// io_pkg
// Shared definitions for the memory-mapped I/O window of the single-cycle
// core: default base address of the switch input port, the word offsets of
// its registers, and small address-decode helpers. The LED output port uses
// the same package.
// ---------------------------------------------------------------------------
package io_pkg;

    // Byte address of register 0 of the switch input port (4-word window).
    localparam logic [15:0] IO_SW_BASE_ADDR = 16'h7800;

    // Word offsets inside the 16-byte switch window.
    localparam logic [1:0] SW_DATA_OFF = 2'd0;
    localparam logic [1:0] SW_CHG_OFF  = 2'd1;
    localparam logic [1:0] SW_MASK_OFF = 2'd2;
    localparam logic [1:0] SW_CNT_OFF  = 2'd3;

    // True when addr lies in [base, base+15]. Computed in 17 bits so a base
    // near the top of the address space cannot wrap.
    function automatic logic in_window(input logic [15:0] addr,
                                       input logic [15:0] base);
        logic [16:0] lo;
        logic [16:0] hi;
        lo = {1'b0, base};
        hi = lo + 17'd15;
        return ({1'b0, addr} >= lo) && ({1'b0, addr} <= hi);
    endfunction

    // Word offset of addr relative to base; byte lane bits [1:0] ignored.
    function automatic logic [1:0] word_offset(input logic [15:0] addr,
                                               input logic [15:0] base);
        logic [15:0] delta;
        delta = addr - base;
        return delta[3:2];
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// ---------------------------------------------------------------------------
// sw_debounce
// Two-flop synchroniser plus counting debouncer for a word of switches.
// A new value is accepted into 'stable' only after sync2 has matched the
// candidate for DEBOUNCE_CYCLES consecutive evaluations; any toggle restarts
// the count.
// Ports:
//   clk            in   core clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   raw            in   SW_W raw switch inputs (asynchronous)
//   stable         out  SW_W debounced value
//   changed_pulse  out  SW_W bits that change on this edge (valid 1 cycle,
//                       combinational, zero when nothing is accepted)
//   cnt            out  current debounce counter
// ---------------------------------------------------------------------------
module sw_debounce #(
    parameter int SW_W            = 32,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [SW_W-1:0]                    raw,
    output logic [SW_W-1:0]                    stable,
    output logic [SW_W-1:0]                    changed_pulse,
    output logic [$clog2(DEBOUNCE_CYCLES)-1:0] cnt
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SW_W-1:0]  sync1_reg;
    logic [SW_W-1:0]  sync2_reg;
    logic [SW_W-1:0]  cand_reg;
    logic [SW_W-1:0]  stable_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             accept;

    // Acceptance happens on the edge where the saturated count is confirmed
    // by one more matching sample. The change mask is exposed combinationally
    // so the parent can merge it into its sticky flags on that same edge.
    assign accept        = (sync2_reg == cand_reg) && (cnt_reg == CNT_MAX)
                           && (cand_reg != stable_reg);
    assign changed_pulse = accept ? (cand_reg ^ stable_reg) : '0;
    assign stable        = stable_reg;
    assign cnt           = cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg  <= '0;
            sync2_reg  <= '0;
            cand_reg   <= '0;
            stable_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            if (sync2_reg != cand_reg) begin
                cand_reg <= sync2_reg;
                cnt_reg  <= '0;
            end else if (cnt_reg < CNT_MAX) begin
                cnt_reg <= cnt_reg + 1'b1;
            end else if (cand_reg != stable_reg) begin
                stable_reg <= cand_reg;
            end
        end
    end

endmodule

// File: rtl/sw_input_port.sv
// ---------------------------------------------------------------------------
// sw_input_port
// Memory-mapped switch input peripheral for the LSU I/O window. Debounces the
// board switches, keeps sticky per-bit change flags (write-1-to-clear), a
// per-bit interrupt mask, and a registered change interrupt.
// Register map (word offsets from BASE_ADDR):
//   +0x0 SW_DATA RO  debounced value      +0x4 SW_CHG  W1C sticky change flags
//   +0x8 SW_MASK RW  interrupt enables    +0xC SW_CNT  RO  debounce counter
// Ports:
//   i_clk, i_rst_n   clock (rising) and asynchronous active-low reset
//   i_io_sw          SW_W raw switch inputs
//   i_addr/i_wdata/i_wren  LSU byte address, store data, store strobe
//   o_hit            address inside the 16-byte window (combinational)
//   o_rdata          read data, 0 outside the window (combinational)
//   o_irq            |(SW_CHG & SW_MASK), registered
// ---------------------------------------------------------------------------
module sw_input_port
    import io_pkg::*;
#(
    parameter int          SW_W            = 32,
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter logic [15:0] BASE_ADDR       = IO_SW_BASE_ADDR
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [SW_W-1:0] i_io_sw,
    input  logic [15:0]     i_addr,
    input  logic [31:0]     i_wdata,
    input  logic            i_wren,
    output logic            o_hit,
    output logic [31:0]     o_rdata,
    output logic            o_irq
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [SW_W-1:0]  stable;
    logic [SW_W-1:0]  changed_pulse;
    logic [CNT_W-1:0] cnt;
    logic [SW_W-1:0]  chg_reg;
    logic [SW_W-1:0]  mask_reg;
    logic             irq_reg;
    logic [1:0]       offset;
    logic             wr_chg;
    logic             wr_mask;
    logic [SW_W-1:0]  clr_bits;

    sw_debounce #(
        .SW_W            (SW_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk           (i_clk),
        .rst_n         (i_rst_n),
        .raw           (i_io_sw),
        .stable        (stable),
        .changed_pulse (changed_pulse),
        .cnt           (cnt)
    );

    assign o_hit   = in_window(i_addr, BASE_ADDR);
    assign offset  = word_offset(i_addr, BASE_ADDR);
    assign wr_chg  = i_wren && o_hit && (offset == SW_CHG_OFF);
    assign wr_mask = i_wren && o_hit && (offset == SW_MASK_OFF);

    assign clr_bits = wr_chg ? i_wdata[SW_W-1:0] : '0;

    // Clear is applied before the OR so a debounce set on the same edge wins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            chg_reg  <= '0;
            mask_reg <= '0;
            irq_reg  <= 1'b0;
        end else begin
            chg_reg <= (chg_reg & ~clr_bits) | changed_pulse;
            if (wr_mask) begin
                mask_reg <= i_wdata[SW_W-1:0];
            end
            irq_reg <= |(chg_reg & mask_reg);
        end
    end

    assign o_irq = irq_reg;

    always_comb begin
        o_rdata = '0;
        if (o_hit) begin
            case (offset)
                SW_DATA_OFF: o_rdata[SW_W-1:0]  = stable;
                SW_CHG_OFF:  o_rdata[SW_W-1:0]  = chg_reg;
                SW_MASK_OFF: o_rdata[SW_W-1:0]  = mask_reg;
                default:     o_rdata[CNT_W-1:0] = cnt;
            endcase
        end
    end

endmodule
